divisor_programable: RTL and testbench

Programmable clock-enable generator placed directly downstream of the frequency selector. It takes the 6-bit divisor code produced there and derives three outputs: a one-cycle `Tick` strobe every N clock cycles, a near-50 % square wave `Clk_out`, and a running tick count. A new divisor is applied only at a period boundary, so changing the selection never produces a short or glitched period.

---
 rtl/divisor_programable.sv | 78 +++++++
 tb/tb_divisor_programable.sv | 423 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/divisor_programable.sv
// -----------------------------------------------------------------------------
// divisor_programable
//   Programmable clock-enable generator. It takes the divisor code from the
//   frequency selector and produces three things: a one-cycle Tick every
//   Div_act cycles, a near-50 % square wave, and a running tick count. A new
//   divisor is loaded only on the wrap edge, so a period is never cut short
//   or glitched.
//
// Ports
//   CLK       in   system clock, rising edge
//   Reset     in   asynchronous, active-high reset
//   En        in   count enable; 0 freezes all state (Tick forced low)
//   Div[5:0]  in   requested divisor N (values below 2 are clamped to 2)
//   Tick      out  registered strobe, one cycle per period
//   Clk_out   out  registered square wave: Div_act>>1 cycles high, rest low
//   Div_act   out  divisor currently in force
//   Pend      out  combinational; high while the clamped Div differs from Div_act
//   Tick_cnt  out  ticks since reset, modulo 256
// -----------------------------------------------------------------------------
module divisor_programable (
  input  logic       CLK,
  input  logic       Reset,
  input  logic       En,
  input  logic [5:0] Div,
  output logic       Tick,
  output logic       Clk_out,
  output logic [5:0] Div_act,
  output logic       Pend,
  output logic [7:0] Tick_cnt
);

  logic [5:0] cnt;
  logic [5:0] div_eff;
  logic [5:0] last_cnt;
  logic [5:0] half_cnt;
  logic       wrap;
  logic       half;

  // Divisors of 0 or 1 would give no room for a high and a low phase.
  assign div_eff  = (Div < 6'd2) ? 6'd2 : Div;

  // Div_act is never below 2, so neither subtraction can underflow.
  assign last_cnt = Div_act - 6'd1;
  assign half_cnt = (Div_act >> 1) - 6'd1;

  // Wrap takes priority: with Div_act = 2 the half point is cnt = 0 and the
  // wrap point is cnt = 1, so they never collide, but the ordering keeps
  // the intent explicit.
  assign wrap = En && (cnt == last_cnt);
  assign half = En && !wrap && (cnt == half_cnt);

  assign Pend = (div_eff != Div_act);

  always_ff @(posedge CLK or posedge Reset) begin
    if (Reset) begin
      cnt      <= 6'd0;
      Div_act  <= 6'd32;
      Tick     <= 1'b0;
      Clk_out  <= 1'b0;
      Tick_cnt <= 8'd0;
    end else if (wrap) begin
      cnt      <= 6'd0;
      Tick     <= 1'b1;
      Clk_out  <= 1'b1;
      Tick_cnt <= Tick_cnt + 8'd1;
      Div_act  <= div_eff;
    end else if (En) begin
      cnt  <= cnt + 6'd1;
      Tick <= 1'b0;
      if (half) begin
        Clk_out <= 1'b0;
      end
    end else begin
      Tick <= 1'b0;
    end
  end

endmodule

// File: tb/tb_divisor_programable.sv
module tb_divisor_programable;

  logic       CLK;
  logic       Reset;
  logic       En;
  logic [5:0] Div;
  logic       Tick;
  logic       Clk_out;
  logic [5:0] Div_act;
  logic       Pend;
  logic [7:0] Tick_cnt;

  divisor_programable dut (
    .CLK      (CLK),
    .Reset    (Reset),
    .En       (En),
    .Div      (Div),
    .Tick     (Tick),
    .Clk_out  (Clk_out),
    .Div_act  (Div_act),
    .Pend     (Pend),
    .Tick_cnt (Tick_cnt)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  typedef struct packed {
    logic       tick;
    logic       clk_o;
    logic [5:0] act;
    logic [7:0] tcnt;
    logic       pend;
  } exp_t;

  exp_t sb_q[$];
  int   n_checks = 0;
  int   n_fail   = 0;

  // Reference model state, updated once per driven edge.
  int   m_cnt;
  int   m_act;
  logic m_tick;
  logic m_clk;
  int   m_tcnt;

  task automatic model_reset();
    m_cnt  = 0;
    m_act  = 32;
    m_tick = 1'b0;
    m_clk  = 1'b0;
    m_tcnt = 0;
    sb_q.delete();
  endtask

  task automatic model_step(input logic en_v, input logic [5:0] div_v);
    int   eff;
    exp_t e;
    eff = (div_v < 6'd2) ? 2 : int'(div_v);
    if (en_v) begin
      if (m_cnt == m_act - 1) begin
        m_cnt  = 0;
        m_tick = 1'b1;
        m_clk  = 1'b1;
        m_tcnt = (m_tcnt + 1) % 256;
        m_act  = eff;
      end else begin
        if (m_cnt == (m_act / 2) - 1) m_clk = 1'b0;
        m_cnt  = m_cnt + 1;
        m_tick = 1'b0;
      end
    end else begin
      m_tick = 1'b0;
    end
    e.tick  = m_tick;
    e.clk_o = m_clk;
    e.act   = m_act[5:0];
    e.tcnt  = m_tcnt[7:0];
    e.pend  = (eff != m_act);
    sb_q.push_back(e);
  endtask

  function automatic exp_t observed();
    exp_t o;
    o.tick  = Tick;
    o.clk_o = Clk_out;
    o.act   = Div_act;
    o.tcnt  = Tick_cnt;
    o.pend  = Pend;
    return o;
  endfunction

  // Drive inputs for one edge, record the expected outcome, sample #1 after.
  task automatic drive(input logic en_v, input logic [5:0] div_v);
    En  = en_v;
    Div = div_v;
    model_step(en_v, div_v);
    @(posedge CLK);
    #1;
  endtask

  task automatic test_reset();
    exp_t e, o;
    int   first_tick;
    Reset = 1'b1; En = 1'b0; Div = 6'd32;
    #3;
    e = '{tick:1'b0, clk_o:1'b0, act:6'd32, tcnt:8'd0, pend:1'b0};
    o = observed();
    n_checks++;
    if (o !== e) begin
      n_fail++;
      $display("FAIL reset_values: got %h expected %h", o, e);
    end
    @(posedge CLK); #1;
    Reset = 1'b0;
    model_reset();
    first_tick = -1;
    for (int i = 1; i <= 40; i++) begin
      drive(1'b1, 6'd32);
      e = sb_q.pop_front(); o = observed(); n_checks++;
      if (o !== e) begin
        n_fail++;
        $display("FAIL reset_run edge %0d: got %h expected %h", i, o, e);
      end
      if (Tick && first_tick < 0) first_tick = i;
    end
    n_checks++;
    if (first_tick != 32) begin
      n_fail++;
      $display("FAIL first_tick: got edge %0d expected edge 32", first_tick);
    end
  endtask

  task automatic test_steady();
    exp_t e, o;
    int   ticks, highs;
    ticks = 0; highs = 0;
    for (int i = 0; i < 64; i++) begin
      drive(1'b1, 6'd32);
      e = sb_q.pop_front(); o = observed(); n_checks++;
      if (o !== e) begin
        n_fail++;
        $display("FAIL steady32: got %h expected %h", o, e);
      end
      ticks += int'(Tick);
      highs += int'(Clk_out);
    end
    n_checks++;
    if (ticks != 2 || highs != 32) begin
      n_fail++;
      $display("FAIL steady32_window: got ticks=%0d highs=%0d expected ticks=2 highs=32", ticks, highs);
    end
    for (int i = 0; i < 40; i++) begin
      drive(1'b1, 6'd12);
      e = sb_q.pop_front(); o = observed(); n_checks++;
      if (o !== e) begin
        n_fail++;
        $display("FAIL switch12: got %h expected %h", o, e);
      end
    end
    ticks = 0; highs = 0;
    for (int i = 0; i < 72; i++) begin
      drive(1'b1, 6'd12);
      e = sb_q.pop_front(); o = observed(); n_checks++;
      if (o !== e) begin
        n_fail++;
        $display("FAIL steady12: got %h expected %h", o, e);
      end
      ticks += int'(Tick);
      highs += int'(Clk_out);
    end
    n_checks++;
    if (ticks != 6 || highs != 36) begin
      n_fail++;
      $display("FAIL steady12_window: got ticks=%0d highs=%0d expected ticks=6 highs=36", ticks, highs);
    end
  endtask

  task automatic test_mid_change();
    exp_t e, o;
    int   guard, k;
    for (int i = 0; i < 40; i++) begin
      drive(1'b1, 6'd32);
      e = sb_q.pop_front(); o = observed(); n_checks++;
      if (o !== e) begin
        n_fail++;
        $display("FAIL mid_load32: got %h expected %h", o, e);
      end
    end
    guard = 0;
    while (m_cnt != 10 && guard < 64) begin
      drive(1'b1, 6'd32);
      e = sb_q.pop_front(); o = observed(); n_checks++;
      if (o !== e) begin
        n_fail++;
        $display("FAIL mid_align: got %h expected %h", o, e);
      end
      guard++;
    end
    Div = 6'd4;
    #1;
    n_checks++;
    if (Pend !== 1'b1) begin
      n_fail++;
      $display("FAIL mid_pend_immediate: got %b expected 1", Pend);
    end
    k = 0;
    do begin
      drive(1'b1, 6'd4);
      e = sb_q.pop_front(); o = observed(); n_checks++;
      if (o !== e) begin
        n_fail++;
        $display("FAIL mid_finish: got %h expected %h", o, e);
      end
      k++;
    end while (!Tick && k < 40);
    n_checks++;
    if (k != 22) begin
      n_fail++;
      $display("FAIL mid_remaining: got %0d edges expected 22", k);
    end
    for (int i = 0; i < 12; i++) begin
      drive(1'b1, 6'd4);
      e = sb_q.pop_front(); o = observed(); n_checks++;
      if (o !== e) begin
        n_fail++;
        $display("FAIL mid_after: got %h expected %h", o, e);
      end
    end
    n_checks++;
    if (Div_act !== 6'd4 || Pend !== 1'b0) begin
      n_fail++;
      $display("FAIL mid_loaded: got act=%0d pend=%b expected act=4 pend=0", Div_act, Pend);
    end
  endtask

  task automatic test_odd_clamp();
    exp_t e, o;
    int   ticks, highs;
    for (int i = 0; i < 40; i++) begin
      drive(1'b1, 6'd19);
      e = sb_q.pop_front(); o = observed(); n_checks++;
      if (o !== e) begin
        n_fail++;
        $display("FAIL odd_load: got %h expected %h", o, e);
      end
    end
    ticks = 0; highs = 0;
    for (int i = 0; i < 38; i++) begin
      drive(1'b1, 6'd19);
      e = sb_q.pop_front(); o = observed(); n_checks++;
      if (o !== e) begin
        n_fail++;
        $display("FAIL odd19: got %h expected %h", o, e);
      end
      ticks += int'(Tick);
      highs += int'(Clk_out);
    end
    n_checks++;
    if (ticks != 2 || highs != 18) begin
      n_fail++;
      $display("FAIL odd19_window: got ticks=%0d highs=%0d expected ticks=2 highs=18", ticks, highs);
    end
    for (int i = 0; i < 25; i++) begin
      drive(1'b1, 6'd0);
      e = sb_q.pop_front(); o = observed(); n_checks++;
      if (o !== e) begin
        n_fail++;
        $display("FAIL clamp0_load: got %h expected %h", o, e);
      end
    end
    ticks = 0; highs = 0;
    for (int i = 0; i < 10; i++) begin
      drive(1'b1, 6'd0);
      e = sb_q.pop_front(); o = observed(); n_checks++;
      if (o !== e) begin
        n_fail++;
        $display("FAIL clamp0: got %h expected %h", o, e);
      end
      ticks += int'(Tick);
      highs += int'(Clk_out);
    end
    n_checks++;
    if (ticks != 5 || highs != 5 || Div_act !== 6'd2) begin
      n_fail++;
      $display("FAIL clamp0_window: got ticks=%0d highs=%0d act=%0d expected ticks=5 highs=5 act=2", ticks, highs, Div_act);
    end
    for (int i = 0; i < 6; i++) begin
      drive(1'b1, 6'd1);
      e = sb_q.pop_front(); o = observed(); n_checks++;
      if (o !== e) begin
        n_fail++;
        $display("FAIL clamp1: got %h expected %h", o, e);
      end
    end
    n_checks++;
    if (Div_act !== 6'd2 || Pend !== 1'b0) begin
      n_fail++;
      $display("FAIL clamp1_act: got act=%0d pend=%b expected act=2 pend=0", Div_act, Pend);
    end
  endtask

  task automatic test_enable();
    exp_t e, o;
    logic held_clk;
    int   guard, k;
    for (int i = 0; i < 8; i++) begin
      drive(1'b1, 6'd4);
      e = sb_q.pop_front(); o = observed(); n_checks++;
      if (o !== e) begin
        n_fail++;
        $display("FAIL en_load4: got %h expected %h", o, e);
      end
    end
    guard = 0;
    while (m_cnt != 1 && guard < 8) begin
      drive(1'b1, 6'd4);
      e = sb_q.pop_front(); o = observed(); n_checks++;
      if (o !== e) begin
        n_fail++;
        $display("FAIL en_align: got %h expected %h", o, e);
      end
      guard++;
    end
    held_clk = m_clk;
    for (int i = 0; i < 5; i++) begin
      drive(1'b0, 6'd4);
      e = sb_q.pop_front(); o = observed(); n_checks++;
      if (o !== e || Tick !== 1'b0 || Clk_out !== held_clk) begin
        n_fail++;
        $display("FAIL en_frozen: got %h expected %h", o, e);
      end
    end
    k = 0;
    do begin
      drive(1'b1, 6'd4);
      e = sb_q.pop_front(); o = observed(); n_checks++;
      if (o !== e) begin
        n_fail++;
        $display("FAIL en_resume: got %h expected %h", o, e);
      end
      k++;
    end while (!Tick && k < 20);
    n_checks++;
    if (k != 3) begin
      n_fail++;
      $display("FAIL en_period: got %0d enabled edges after freeze expected 3", k);
    end
  endtask

  task automatic test_wrap();
    exp_t e, o;
    logic [7:0] prev;
    logic       seen;
    seen = 1'b0;
    prev = Tick_cnt;
    for (int i = 0; i < 1024; i++) begin
      drive(1'b1, 6'd4);
      e = sb_q.pop_front(); o = observed(); n_checks++;
      if (o !== e) begin
        n_fail++;
        $display("FAIL wrap_run %0d: got %h expected %h", i, o, e);
      end
      if (prev == 8'd255 && Tick_cnt == 8'd0) seen = 1'b1;
      prev = Tick_cnt;
    end
    n_checks++;
    if (seen !== 1'b1) begin
      n_fail++;
      $display("FAIL tick_cnt_wrap: got seen=%b expected 1", seen);
    end
  endtask

  task automatic test_async_reset();
    exp_t e, o;
    for (int i = 0; i < 6; i++) begin
      drive(1'b1, 6'd4);
      e = sb_q.pop_front(); o = observed(); n_checks++;
      if (o !== e) begin
        n_fail++;
        $display("FAIL async_pre: got %h expected %h", o, e);
      end
    end
    #2;
    Reset = 1'b1;
    #1;
    e = '{tick:1'b0, clk_o:1'b0, act:6'd32, tcnt:8'd0, pend:1'b1};
    o = observed();
    n_checks++;
    if (o !== e) begin
      n_fail++;
      $display("FAIL async_reset: got %h expected %h", o, e);
    end
    @(posedge CLK); #1;
    Reset = 1'b0;
    model_reset();
    for (int i = 0; i < 40; i++) begin
      drive(1'b1, 6'd4);
      e = sb_q.pop_front(); o = observed(); n_checks++;
      if (o !== e) begin
        n_fail++;
        $display("FAIL async_resume: got %h expected %h", o, e);
      end
    end
  endtask

  initial begin
    Reset = 1'b1;
    En    = 1'b0;
    Div   = 6'd32;
    model_reset();
    test_reset();
    test_steady();
    test_mid_change();
    test_odd_clamp();
    test_enable();
    test_wrap();
    test_async_reset();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
